// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC generation, IF/ID pipeline register, stall/redirect/HALT control.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                  PC_W     = 6,
    parameter int                  INSTR_W  = 16,
    parameter int                  OPC_W    = 4,
    parameter logic [OPC_W-1:0]    HALT_OPC = 4'hF,
    parameter logic [INSTR_W-1:0]  NOP      = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PC_W-1:0]    i_pc_cur,
    input  logic [INSTR_W-1:0] i_instr_in,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_target,
    output logic [PC_W-1:0]    o_pc_next,
    output logic               o_pc_write,
    output logic [INSTR_W-1:0] o_ifid_instr,
    output logic [PC_W-1:0]    o_ifid_pc,
    output logic [PC_W-1:0]    o_ifid_pc_plus1,
    output logic               o_ifid_valid,
    output logic               o_halted,
    output logic [15:0]        o_fetch_count,
    output logic [15:0]        o_flush_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSHED = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [INSTR_W-1:0]   r_instr;
    logic [INSTR_W-1:0]   w_instr_nxt;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_pc_nxt;
    logic [PC_W-1:0]      r_pc_plus1;
    logic [PC_W-1:0]      w_pc_plus1_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [PC_W-1:0]      w_pc_inc;
    logic                 w_capture;
    logic                 w_is_halt;

    assign w_pc_inc  = i_pc_cur + PC_W'(1);
    assign w_is_halt = (i_instr_in[INSTR_W-1 -: OPC_W] == HALT_OPC);
    assign w_capture = !i_redirect && !i_stall && (r_state != ST_HALTED);

    // Next-PC select: redirect beats HALT, HALT beats stall.
    always_comb begin
        o_pc_next  = {PC_W{1'b0}};
        o_pc_write = 1'b0;
        if (i_rst) begin
            o_pc_next  = {PC_W{1'b0}};
            o_pc_write = 1'b0;
        end else if (i_redirect) begin
            o_pc_next  = i_redirect_target;
            o_pc_write = 1'b1;
        end else if (r_state == ST_HALTED || i_stall) begin
            o_pc_next  = i_pc_cur;
            o_pc_write = 1'b0;
        end else begin
            o_pc_next  = w_pc_inc;
            o_pc_write = 1'b1;
        end
    end

    // Next IF/ID contents and FSM state; FLUSHED captures exactly like RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_instr_nxt    = r_instr;
        w_pc_nxt       = r_pc;
        w_pc_plus1_nxt = r_pc_plus1;
        w_valid_nxt    = r_valid;
        if (i_redirect) begin
            w_instr_nxt = NOP;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_FLUSHED;
        end else if (i_stall) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                ST_HALTED: begin
                    w_instr_nxt = NOP;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_HALTED;
                end
                ST_RUN, ST_FLUSHED: begin
                    w_instr_nxt    = i_instr_in;
                    w_pc_nxt       = i_pc_cur;
                    w_pc_plus1_nxt = w_pc_inc;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = w_is_halt ? ST_HALTED : ST_RUN;
                end
                default: begin
                    w_instr_nxt = NOP;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State and IF/ID register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_instr    <= NOP;
            r_pc       <= {PC_W{1'b0}};
            r_pc_plus1 <= {PC_W{1'b0}};
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_instr    <= w_instr_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_plus1 <= w_pc_plus1_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign o_ifid_instr    = r_instr;
    assign o_ifid_pc       = r_pc;
    assign o_ifid_pc_plus1 = r_pc_plus1;
    assign o_ifid_valid    = r_valid;
    assign o_halted        = (r_state == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating counters of valid captures and taken redirects.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (w_capture && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'h0001;
            end
            if (i_redirect && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'h0001;
            end
        end
    end

    assign o_fetch_count = r_fetch_cnt;
    assign o_flush_count = r_flush_cnt;
`else
    assign o_fetch_count = 16'h0000;
    assign o_flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected IF/ID state per edge,
// which is popped and compared after the edge; next-PC outputs are checked before each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [5:0]  i_pc_cur = 6'd0;
    logic [15:0] i_instr_in = 16'h0000;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [5:0]  i_redirect_target = 6'd0;
    logic [5:0]  o_pc_next;
    logic        o_pc_write;
    logic [15:0] o_ifid_instr;
    logic [5:0]  o_ifid_pc;
    logic [5:0]  o_ifid_pc_plus1;
    logic        o_ifid_valid;
    logic        o_halted;
    logic [15:0] o_fetch_count;
    logic [15:0] o_flush_count;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_pc_cur          (i_pc_cur),
        .i_instr_in        (i_instr_in),
        .i_stall           (i_stall),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .o_pc_next         (o_pc_next),
        .o_pc_write        (o_pc_write),
        .o_ifid_instr      (o_ifid_instr),
        .o_ifid_pc         (o_ifid_pc),
        .o_ifid_pc_plus1   (o_ifid_pc_plus1),
        .o_ifid_valid      (o_ifid_valid),
        .o_halted          (o_halted),
        .o_fetch_count     (o_fetch_count),
        .o_flush_count     (o_flush_count)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [5:0]  pc;
        logic [5:0]  pp1;
        logic        valid;
        logic        halted;
        logic [15:0] fc;
        logic [15:0] flc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] imem [0:63];
    int          n_vec = 0;
    int          n_err = 0;

    // reference model state
    logic [5:0]  m_pc = 6'd0;
    logic [15:0] m_instr = 16'h0000;
    logic [5:0]  m_ifpc = 6'd0;
    logic [5:0]  m_pp1 = 6'd0;
    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    logic [15:0] m_fc = 16'h0000;
    logic [15:0] m_flc = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic stall, input logic redir, input logic [5:0] tgt);
        exp_t        e;
        logic [5:0]  enext;
        logic        ewr;
        @(negedge clk);
        i_rst = rst;
        i_stall = stall;
        i_redirect = redir;
        i_redirect_target = tgt;
        i_pc_cur = m_pc;
        i_instr_in = imem[m_pc];
        #1;
        if (rst) begin
            enext = 6'd0; ewr = 1'b0;
        end else if (redir) begin
            enext = tgt; ewr = 1'b1;
        end else if (m_halted || stall) begin
            enext = m_pc; ewr = 1'b0;
        end else begin
            enext = m_pc + 6'd1; ewr = 1'b1;
        end
        chk("pc_next", {26'd0, o_pc_next}, {26'd0, enext});
        chk("pc_write", {31'd0, o_pc_write}, {31'd0, ewr});

        if (rst) begin
            m_instr = 16'h0000; m_ifpc = 6'd0; m_pp1 = 6'd0; m_valid = 1'b0;
            m_halted = 1'b0; m_fc = 16'h0000; m_flc = 16'h0000;
        end else if (redir) begin
            m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
`ifdef FETCH_PERF_CNT_EN
            if (m_flc != 16'hFFFF) m_flc = m_flc + 16'd1;
`endif
        end else if (stall) begin
            m_valid = m_valid;
        end else if (m_halted) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = imem[m_pc]; m_ifpc = m_pc; m_pp1 = m_pc + 6'd1; m_valid = 1'b1;
            m_halted = (imem[m_pc][15:12] == 4'hF);
`ifdef FETCH_PERF_CNT_EN
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
`endif
        end
        e = '{instr: m_instr, pc: m_ifpc, pp1: m_pp1, valid: m_valid, halted: m_halted, fc: m_fc, flc: m_flc};
        sb_q.push_back(e);
        if (rst) m_pc = 6'd0;
        else if (ewr) m_pc = enext;

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("ifid_valid", {31'd0, o_ifid_valid}, {31'd0, e.valid});
            chk("halted", {31'd0, o_halted}, {31'd0, e.halted});
            chk("fetch_count", {16'd0, o_fetch_count}, {16'd0, e.fc});
            chk("flush_count", {16'd0, o_flush_count}, {16'd0, e.flc});
            chk("ifid_instr", {16'd0, o_ifid_instr}, {16'd0, e.instr});
            if (e.valid || rst) begin
                chk("ifid_pc", {26'd0, o_ifid_pc}, {26'd0, e.pc});
                chk("ifid_pc_plus1", {26'd0, o_ifid_pc_plus1}, {26'd0, e.pp1});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 16'h1000 + 16'(i);
        imem[9] = 16'hF000;

        cycle(1'b1, 1'b0, 1'b0, 6'd0);                 // reset
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 6'd0);      // fetch 0..4
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 6'd0);      // stall at pc 5
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 6'd0);      // 5..9, HALT at 9
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 6'd0);      // halted bubbles
        cycle(1'b0, 1'b1, 1'b1, 6'd20);                // redirect with stall
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b0, 1'b0, 1'b1, 6'd60);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 6'd0);      // 60..63 wrap to 0,1
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 6'd0);     // run into HALT again
        cycle(1'b0, 1'b1, 1'b0, 6'd0);                 // stall while halted
        cycle(1'b1, 1'b1, 1'b0, 6'd0);                 // reset mid-stall
        repeat (9) cycle(1'b0, 1'b0, 1'b0, 6'd0);      // 0..8, pc_cur now 9
        cycle(1'b0, 1'b0, 1'b1, 6'd3);                 // redirect squashes HALT
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b0, 1'b0, 1'b1, 6'd0);                 // redirect to 0
        repeat (300) begin
            cycle(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                  6'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
